mips_mc_controller: RTL
=======================

// Module: mips_mc_controller
// PURPOSE
//  Control FSM for the multi-cycle MIPS datapath. Sits directly upstream of the datapath.
//  Consumes OPC/Func/zero from it and drives every mux select, write enable and ALU_operation.
//  Each instruction is sequenced over 3-5 clocks: FETCH, DECODE, then an opcode-specific path.
//  Flags an undefined opcode or funct by halting until reset.
// PARAMETERS
//  None. The opcode/funct encodings below are fixed localparams.
// PORTS
//  clk            in   1  clock; all state updates on the rising edge
//  rst            in   1  reset; synchronous, active-high
//  OPC            in   6  IR[31:26] from the datapath
//  Func           in   6  IR[5:0] from the datapath
//  zero           in   1  ALU zero flag (valid in BRANCH)
//  pc_write       out  1  load PC (branch condition already folded in)
//  ir_write       out  1  load IR and latch instruction
//  IorD           out  1  memory address: 0=PC, 1=ALUOut
//  MemRead        out  1  memory read strobe
//  MemWrite       out  1  memory write strobe
//  regwrite       out  1  register file write enable
//  RegDst         out  2  write reg: 00=rt, 01=rd, 10=$31
//  MemToReg       out  2  write data: 00=ALUOut, 01=MDR, 10=PC
//  ALUSrcA        out  1  0=PC, 1=A
//  ALUSrcB        out  2  00=B, 01=4, 10=SE(imm), 11=SE(imm)<<2
//  ALU_operation  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
//  PCSrc          out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}, 11=A (jr)
//  instr_done     out  1  one-cycle pulse in the last state of each instruction
//  halted         out  1  high in HALT
// BEHAVIOUR
//  Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000,
//   slti=001010, andi=001100, j=000010, jal=000011.
//  R funct: add=100000, sub=100010, and=100100, or=100101, slt=101010, jr=001000.
//  Reset and default levels:
//   - While rst=1, all outputs are 0 (write strobes gated combinationally).
//   - The edge with rst=1 puts the state in FETCH; the first FETCH follows rst deassertion.
//   - Reset mid-instruction abandons that instruction; no partial write after the reset edge.
//  Outputs are Moore decodes of state. Sole Mealy term: pc_write in BRANCH.
//   Unlisted outputs in a state are 0.
//  OPC and Func are latched into internal registers in DECODE. Later states use only the latched copies.
//  States and transitions:
//   - FETCH: MemRead, ir_write, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00, pc_write -> DECODE.
//   - DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by opcode:
//     lw/sw -> MEM_ADDR; R(non-jr) -> R_EXEC; R jr -> JR; beq/bne -> BRANCH;
//     addi/slti/andi -> IMM_EXEC; j -> JUMP; jal -> JAL; anything else -> HALT.
//   - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add -> MEM_RD (lw) or MEM_WR (sw).
//   - MEM_RD: MemRead, IorD=1 -> MEM_WB.
//   - MEM_WB: regwrite, RegDst=00, MemToReg=01, instr_done -> FETCH.
//   - MEM_WR: MemWrite, IorD=1, instr_done -> FETCH.
//   - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_operation from funct -> R_WB.
//     Undefined funct -> HALT, with no register write.
//   - R_WB: regwrite, RegDst=01, MemToReg=00, instr_done -> FETCH.
//   - IMM_EXEC: ALUSrcA=1, ALUSrcB=10; add/slt/and for addi/slti/andi -> IMM_WB.
//   - IMM_WB: regwrite, RegDst=00, MemToReg=00, instr_done -> FETCH.
//   - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, instr_done -> FETCH.
//     pc_write = (beq & zero) | (bne & ~zero).
//   - JUMP: PCSrc=10, pc_write, instr_done -> FETCH.
//   - JAL: regwrite, RegDst=10, MemToReg=10, PCSrc=10, pc_write, instr_done -> FETCH.
//     $31 receives the already-incremented PC+4; register write and PC load share the same edge.
//   - JR: PCSrc=11, pc_write, instr_done -> FETCH.
//   - HALT: halted=1, all strobes 0; stays in HALT until rst.
//  Latency in clocks: lw 5; sw/R/imm 4; beq/bne/j/jal/jr 3.
//  Never asserted together: MemRead with MemWrite, or regwrite with MemWrite.
//  State encoding: 4-bit binary, FETCH=0; unused codes -> HALT.
// TESTING
//  1. Hold rst for 2 clk, then release -> all outputs 0 during rst.
//     First cycle after release: ir_write=1, pc_write=1, MemRead=1.
//  2. lw (OPC=100011) -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB.
//     regwrite=1 with MemToReg=01 only in cycle 5; instr_done in cycle 5.
//  3. R add (Func=100000) then sub (100010) -> ALU_operation 010 then 110 in R_EXEC.
//     RegDst=01 and regwrite in R_WB; 4 cycles each.
//  4. beq with zero=1 -> pc_write=1, PCSrc=01 in cycle 3; with zero=0 -> pc_write=0.
//     bne gives the inverse in both cases.
//  5. jal -> cycle 3: regwrite=1, RegDst=10, MemToReg=10, PCSrc=10, pc_write=1.
//     jr (Func=001000) -> PCSrc=11, pc_write in cycle 3.
//  6. OPC=111111 -> HALT after DECODE: halted=1, no strobes for 20 clk.
//     rst mid-MEM_RD -> FETCH, no regwrite.

Source files
------------

// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
//
// Control FSM for the multi-cycle MIPS datapath. Every instruction runs
// FETCH, then DECODE, then a short opcode-specific tail of 1-3 states. The FSM
// drives every mux select, write enable and ALU operation of the datapath.
// An undefined opcode or R-type funct parks the FSM in HALT until reset.
//
// Ports
//   clk            in   1  clock, rising edge
//   rst            in   1  synchronous active-high reset; forces all outputs to 0
//   OPC            in   6  IR[31:26] from the datapath
//   Func           in   6  IR[5:0] from the datapath
//   zero           in   1  ALU zero flag, consumed only in BRANCH
//   pc_write       out  1  load PC (branch condition folded in)
//   ir_write       out  1  load IR
//   IorD           out  1  memory address select: 0=PC, 1=ALUOut
//   MemRead        out  1  memory read strobe
//   MemWrite       out  1  memory write strobe
//   regwrite       out  1  register file write enable
//   RegDst         out  2  write register: 00=rt, 01=rd, 10=$31
//   MemToReg       out  2  write data: 00=ALUOut, 01=MDR, 10=PC
//   ALUSrcA        out  1  0=PC, 1=A
//   ALUSrcB        out  2  00=B, 01=4, 10=SE(imm), 11=SE(imm)<<2
//   ALU_operation  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
//   PCSrc          out  2  00=ALU, 01=ALUOut, 10=jump target, 11=A
//   instr_done     out  1  pulse in the last state of each instruction
//   halted         out  1  high while in HALT
//
// The current state is held in state_q (4-bit binary, FETCH=0) so checkers
// can bind to it directly.
// -----------------------------------------------------------------------------
module mips_mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPC,
  input  logic [5:0] Func,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       regwrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_operation,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       halted
);

  // Opcodes
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  // R-type funct codes
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  // ALU operations
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_IMM_EXEC = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd14
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] opc_q, func_q;

  function automatic logic r_func_ok(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_SLT);
  endfunction

  function automatic logic [2:0] r_alu_op(input logic [5:0] f);
    logic [2:0] op;
    op = ALU_AND;
    case (f)
      F_ADD:   op = ALU_ADD;
      F_SUB:   op = ALU_SUB;
      F_AND:   op = ALU_AND;
      F_OR:    op = ALU_OR;
      F_SLT:   op = ALU_SLT;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // State register. OPC/Func are captured on the edge that leaves DECODE, so
  // every state after DECODE works from a stable copy even though the
  // datapath IR inputs may change.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opc_q  <= OPC;
        func_q <= Func;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. DECODE dispatches on the live IR fields because the
  // latched copies only become valid on the edge leaving DECODE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = S_HALT;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (OPC)
          OP_R:                      state_d = (Func == F_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI: state_d = S_IMM_EXEC;
          OP_J:                      state_d = S_JUMP;
          OP_JAL:                    state_d = S_JAL;
          default:                   state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: state_d = (opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = S_FETCH;
      S_R_EXEC:   state_d = r_func_ok(func_q) ? S_R_WB : S_HALT;
      S_R_WB:     state_d = S_FETCH;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_JR:       state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Moore on state except pc_write in BRANCH. Every output is
  // forced low while rst is high so a reset landing mid-instruction cannot
  // leak a write strobe in the cycle before the reset edge takes effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    regwrite      = 1'b0;
    RegDst        = 2'b00;
    MemToReg      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALU_operation = ALU_AND;
    PCSrc         = 2'b00;
    instr_done    = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead       = 1'b1;
          ir_write      = 1'b1;
          ALUSrcB       = 2'b01;
          ALU_operation = ALU_ADD;
          pc_write      = 1'b1;
        end
        S_DECODE: begin
          // Branch target PC+4 + (imm<<2) precomputed into ALUOut.
          ALUSrcB       = 2'b11;
          ALU_operation = ALU_ADD;
        end
        S_MEM_ADDR: begin
          ALUSrcA       = 1'b1;
          ALUSrcB       = 2'b10;
          ALU_operation = ALU_ADD;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          regwrite   = 1'b1;
          MemToReg   = 2'b01;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = 1'b1;
        end
        S_R_EXEC: begin
          ALUSrcA       = 1'b1;
          ALU_operation = r_alu_op(func_q);
        end
        S_R_WB: begin
          regwrite   = 1'b1;
          RegDst     = 2'b01;
          instr_done = 1'b1;
        end
        S_IMM_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (opc_q)
            OP_SLTI: ALU_operation = ALU_SLT;
            OP_ANDI: ALU_operation = ALU_AND;
            default: ALU_operation = ALU_ADD;
          endcase
        end
        S_IMM_WB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA       = 1'b1;
          ALU_operation = ALU_SUB;
          PCSrc         = 2'b01;
          instr_done    = 1'b1;
          pc_write      = ((opc_q == OP_BEQ) &&  zero) ||
                          ((opc_q == OP_BNE) && !zero);
        end
        S_JUMP: begin
          PCSrc      = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          // PC already holds PC+4 from FETCH, so $31 gets the return address
          // on the same edge that loads the jump target.
          regwrite   = 1'b1;
          RegDst     = 2'b10;
          MemToReg   = 2'b10;
          PCSrc      = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_JR: begin
          PCSrc      = 2'b11;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

endmodule
